// File: rtl/fifo_word_packer_pkg.sv
// Shared widths, types and lane helper for the byte-to-word packer.
package fifo_word_packer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PACK   = 4;
  localparam int unsigned CNT_W  = $clog2(PACK + 1);
  localparam int unsigned OUT_W  = DATA_W * PACK;

  typedef logic [DATA_W-1:0] entry_t;
  typedef logic [OUT_W-1:0]  word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    cnt_t  count;
    word_t data;
  } out_word_t;

  // Low bit of byte lane idx inside a packed word.
  function automatic int unsigned lane_lo(input cnt_t idx);
    return 32'(idx) * DATA_W;
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read port plus wide valid/ready output stream of the packer.
interface fifo_word_packer_if;
  import fifo_word_packer_pkg::*;

  logic   rd_val;
  entry_t rd_data;
  logic   rd_en;
  logic   flush;
  word_t  out_data;
  cnt_t   out_count;
  logic   out_valid;
  logic   out_ready;
  logic   busy;

  modport master (
    input  rd_val, rd_data, flush, out_ready,
    output rd_en, out_data, out_count, out_valid, busy
  );

  modport slave (
    output rd_val, rd_data, flush, out_ready,
    input  rd_en, out_data, out_count, out_valid, busy
  );

endinterface

// File: rtl/fifo_word_packer_pack_out_reg.sv
// Valid/ready holding register for packed words; loads only when the caller knows it is free.
module pack_out_reg
  import fifo_word_packer_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      load_i,
  input  out_word_t word_i,
  input  logic      ready_i,
  output out_word_t word_o,
  output logic      valid_o
);

  out_word_t word_q;
  logic      valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      word_q  <= word_i;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign word_o  = word_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fifo_word_packer.sv
// Drains a first-word-fall-through byte FIFO and packs PACK bytes (or a flushed partial) per word.
module fifo_word_packer
  import fifo_word_packer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  fifo_word_packer_if.master bus
);

  word_t     acc_q, acc_d;
  cnt_t      acc_cnt_q, acc_cnt_d;
  logic      closed_q, closed_d;
  logic      xfer, pop, out_valid;
  out_word_t acc_word, out_word;

  assign xfer = closed_q & (~out_valid | bus.out_ready);
  // A closed accumulator may only refill in the cycle its word moves out.
  assign pop  = reset & bus.rd_val & (~closed_q | xfer);

  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    closed_d  = closed_q & ~xfer;
    if (xfer) begin
      acc_d     = '0;
      acc_cnt_d = '0;
    end
    if (pop) begin
      acc_d[lane_lo(acc_cnt_d) +: DATA_W] = bus.rd_data;
      acc_cnt_d                           = acc_cnt_d + cnt_t'(1);
    end
    if ((acc_cnt_d == cnt_t'(PACK)) || (bus.flush && (acc_cnt_d != '0))) begin
      closed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      acc_cnt_q <= '0;
      closed_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      closed_q  <= closed_d;
    end
  end

  assign acc_word = '{count: acc_cnt_q, data: acc_q};

  pack_out_reg u_out_reg (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (xfer),
    .word_i  (acc_word),
    .ready_i (bus.out_ready),
    .word_o  (out_word),
    .valid_o (out_valid)
  );

  assign bus.rd_en     = pop;
  assign bus.out_data  = out_word.data;
  assign bus.out_count = out_word.count;
  assign bus.out_valid = out_valid;
  assign bus.busy      = reset & ((acc_cnt_q != '0) | closed_q | out_valid);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench: queue-based FIFO and word model compared every cycle, plus literal word checks.
module tb_fifo_word_packer;
  import fifo_word_packer_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  fifo_word_packer_if bus ();

  fifo_word_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int stall_cnt = 0;

  entry_t fifo[$];
  entry_t cur[$];
  logic   m_stg_v = 1'b0;
  logic   m_out_v = 1'b0;
  word_t  m_stg_w, m_out_w;
  cnt_t   m_stg_n, m_out_n;

  word_t  log_w[$];
  cnt_t   log_n[$];
  int     log_cyc[$];
  int     pop_cyc[$];

  logic   s_rd_en, s_rd_val, s_flush, s_out_ready, s_out_valid;
  entry_t s_rd_data;
  word_t  s_out_data;
  cnt_t   s_out_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic word_t pack_bytes(input entry_t b[$]);
    word_t w = '0;
    for (int i = 0; i < b.size(); i++) w[i*DATA_W +: DATA_W] = b[i];
    return w;
  endfunction

  task automatic refresh();
    bus.rd_val  = (fifo.size() != 0);
    bus.rd_data = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  task automatic push(input entry_t b);
    fifo.push_back(b);
    refresh();
  endtask

  // One clock: compare at negedge, advance FIFO and word model at posedge, drive at +1.
  task automatic tick();
    logic exp_rden, accept, xf, popped;
    @(negedge clk);
    if (reset) begin
      exp_rden = bus.rd_val && (!m_stg_v || !m_out_v || bus.out_ready);
      chk("rd_en", 64'(bus.rd_en), 64'(exp_rden));
      chk("out_valid", 64'(bus.out_valid), 64'(m_out_v));
      if (m_out_v) begin
        chk("out_data", 64'(bus.out_data), 64'(m_out_w));
        chk("out_count", 64'(bus.out_count), 64'(m_out_n));
      end
      chk("busy", 64'(bus.busy), 64'((cur.size() != 0) || m_stg_v || m_out_v));
    end
    s_rd_en     = bus.rd_en;
    s_rd_val    = bus.rd_val;
    s_rd_data   = bus.rd_data;
    s_flush     = bus.flush;
    s_out_ready = bus.out_ready;
    s_out_valid = bus.out_valid;
    s_out_data  = bus.out_data;
    s_out_count = bus.out_count;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      cur.delete();
      m_stg_v = 1'b0;
      m_out_v = 1'b0;
    end else begin
      accept = m_out_v && s_out_ready;
      xf     = m_stg_v && (!m_out_v || s_out_ready);
      popped = s_rd_en && s_rd_val;
      if (s_out_valid && s_out_ready) begin
        log_w.push_back(s_out_data);
        log_n.push_back(s_out_count);
        log_cyc.push_back(cyc);
      end
      if (s_rd_val && !s_rd_en) stall_cnt++;
      if (accept) m_out_v = 1'b0;
      if (xf) begin
        m_out_v = 1'b1;
        m_out_w = m_stg_w;
        m_out_n = m_stg_n;
        m_stg_v = 1'b0;
      end
      if (popped) begin
        cur.push_back(s_rd_data);
        void'(fifo.pop_front());
        pop_cyc.push_back(cyc);
      end
      if ((cur.size() == PACK) || (s_flush && (cur.size() != 0))) begin
        m_stg_w = pack_bytes(cur);
        m_stg_n = cnt_t'(cur.size());
        m_stg_v = 1'b1;
        cur.delete();
      end
    end
    #1;
    refresh();
  endtask

  task automatic wait_idle(input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      if ((fifo.size() == 0) && !bus.busy) break;
      tick();
    end
    if (i == max_cyc) chk("idle_timeout", 64'(bus.busy), 64'(0));
  endtask

  task automatic flush_pulse();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    bus.rd_val    = 1'b0;
    bus.rd_data   = '0;

    // Reset held with a non-empty FIFO, then the first full word.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (3) tick();
    chk("rst_rd_en", 64'(bus.rd_en), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    reset = 1'b1;
    tick();
    chk("pop_after_release", 64'(fifo.size()), 64'(3));
    wait_idle(20);
    chk("t2_words", 64'(log_w.size()), 64'(1));
    chk("t2_data", 64'(log_w[0]), 64'h44332211);
    chk("t2_count", 64'(log_n[0]), 64'(4));
    chk("t2_latency", 64'(log_cyc[0] - pop_cyc[3]), 64'(2));

    // Flushed partial, dropped empty flush, flush coinciding with a pop.
    push(8'hAA); push(8'hBB);
    repeat (3) tick();
    flush_pulse();
    wait_idle(20);
    chk("t3_partial_data", 64'(log_w[1]), 64'h0000BBAA);
    chk("t3_partial_count", 64'(log_n[1]), 64'(2));
    flush_pulse();
    repeat (4) tick();
    chk("t3_empty_flush", 64'(log_w.size()), 64'(2));
    push(8'hCC);
    flush_pulse();
    wait_idle(20);
    chk("t3_pop_flush_data", 64'(log_w[2]), 64'h000000CC);
    chk("t3_pop_flush_count", 64'(log_n[2]), 64'(1));

    // Backpressure: first word held, second closed, FIFO not drained.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) push(entry_t'(i));
    repeat (16) tick();
    chk("t4_hold_valid", 64'(bus.out_valid), 64'(1));
    chk("t4_hold_data", 64'(bus.out_data), 64'h04030201);
    chk("t4_rd_en_low", 64'(bus.rd_en), 64'(0));
    chk("t4_fifo_left", 64'(fifo.size()), 64'(2));
    chk("t4_no_accept", 64'(log_w.size()), 64'(3));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && fifo.size() != 0; i++) tick();
    chk("t4_drain", 64'(fifo.size()), 64'(0));
    repeat (2) tick();
    flush_pulse();
    wait_idle(20);
    chk("t4_word0", 64'(log_w[3]), 64'h04030201);
    chk("t4_word1", 64'(log_w[4]), 64'h08070605);
    chk("t4_tail", 64'(log_w[5]), 64'h00000A09);
    chk("t4_tail_count", 64'(log_n[5]), 64'(2));

    // Streaming: one byte per cycle, no stalls.
    stall_cnt = 0;
    for (int i = 0; i < 64; i++) push(entry_t'(i));
    wait_idle(100);
    chk("t5_words", 64'(log_w.size()), 64'(22));
    chk("t5_stalls", 64'(stall_cnt), 64'(0));
    chk("t5_first", 64'(log_w[6]), 64'h03020100);
    chk("t5_last", 64'(log_w[21]), 64'h3F3E3D3C);

    // Reset mid-word discards the partial bytes.
    push(8'h51); push(8'h52); push(8'h53);
    repeat (5) tick();
    chk("t6_busy_before", 64'(bus.busy), 64'(1));
    reset = 1'b0;
    #1;
    chk("t6_async_valid", 64'(bus.out_valid), 64'(0));
    chk("t6_async_busy", 64'(bus.busy), 64'(0));
    chk("t6_async_count", 64'(bus.out_count), 64'(0));
    chk("t6_async_data", 64'(bus.out_data), 64'(0));
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    repeat (3) tick();
    chk("t6_rd_en_in_rst", 64'(bus.rd_en), 64'(0));
    chk("t6_fifo_kept", 64'(fifo.size()), 64'(4));
    reset = 1'b1;
    wait_idle(20);
    chk("t6_words", 64'(log_w.size()), 64'(23));
    chk("t6_fresh_data", 64'(log_w[22]), 64'h64636261);
    chk("t6_fresh_count", 64'(log_n[22]), 64'(4));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
